// File: rtl/stack_pkg.sv
// stack_pkg: shared operation encoding and sizing helper for the stack unit.
package stack_pkg;
  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } stack_op_t;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/stack_regfile.sv
// stack_regfile: unreset word array with one synchronous write and one asynchronous read port.
module stack_regfile #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/stack_unit.sv
// stack_unit: LIFO with combinational top-of-stack and overflow/underflow reporting.
// Define STACK_ERR_STICKY_EN to hold err high from the first illegal op until reset.
module stack_unit import stack_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int CW    = cnt_w(DEPTH),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] tos,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full,
  output logic              err
);
  logic [CW-1:0] sp_q, sp_d, sp_m1;
  logic err_q, err_d;
  logic push_ok, repl_ok, pop_ok, ill, we;
  logic [AW-1:0] waddr;
  logic [DATA_W-1:0] rdata;
  stack_op_t op;
  assign op    = stack_op_t'({push, pop});
  assign empty = sp_q == '0;
  assign full  = sp_q == CW'(DEPTH);
  assign sp_m1 = sp_q - CW'(1);
  // REPL on an empty stack degenerates into a plain push
  always_comb begin
    push_ok = (op == OP_PUSH && !full) || (op == OP_REPL && empty);
    repl_ok = op == OP_REPL && !empty;
    pop_ok  = op == OP_POP && !empty;
    ill     = (op == OP_PUSH && full) || (op == OP_POP && empty);
    we      = push_ok || repl_ok;
    waddr   = repl_ok ? AW'(sp_m1) : AW'(sp_q);
    sp_d    = push_ok ? sp_q + CW'(1) : pop_ok ? sp_m1 : sp_q;
`ifdef STACK_ERR_STICKY_EN
    err_d   = err_q || ill;
`else
    err_d   = ill;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end
  stack_regfile #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rf (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(din),
    .raddr(AW'(sp_m1)),
    .rdata(rdata)
  );
  assign tos   = empty ? '0 : rdata;
  assign count = sp_q;
  assign err   = err_q;
endmodule
